dmem_bus_bridge: RTL and testbench

//  Converts the single-cycle core's combinational data-memory port into a registered

---
 rtl/dmem_bus_if.sv | 20 ++
 rtl/dmem_bus_bridge.sv | 124 ++++++++++++
 tb/tb_dmem_bus_bridge.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_bus_if.sv
// Data-memory bus between the core-side bridge (master) and the memory system (slave).
// Single outstanding request; the request fields stay stable while mem_valid is high.
interface dmem_bus_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/dmem_bus_bridge.sv
// Turns the single-cycle core's combinational data-memory port into one registered
// valid/ready bus transfer per load/store, stalling the core until it completes or times out.
module dmem_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        core_req,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [3:0]  core_wmask,
  output logic [31:0] core_rdata,
  output logic        core_stall,
  output logic        core_err,
  dmem_bus_if.master  bus
);

  // A zero timeout disables the timer, but it still needs at least one bit to exist.
  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST =
    TMR_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              valid_q, valid_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              timeout_hit;
  logic              unused_addr_lsb;

  // The bus is word-addressed; byte lanes are selected by the strobes instead.
  assign unused_addr_lsb = ^core_addr[1:0];

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer_q == TMR_LAST);

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    timer_d = timer_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (core_req) begin
          addr_d  = {core_addr[31:2], 2'b00};
          wdata_d = core_wdata;
          wstrb_d = core_wmask;
          valid_d = 1'b1;
          timer_d = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // A ready arriving on the last allowed cycle still counts as a normal completion.
        if (bus.mem_ready) begin
          rdata_d = bus.mem_rdata;
          valid_d = 1'b0;
          state_d = DONE;
        end else if (timeout_hit) begin
          rdata_d = ERR_RDATA;
          err_d   = 1'b1;
          valid_d = 1'b0;
          state_d = DONE;
        end else if (TIMEOUT_CYCLES != 0) begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // Register stage: bus request, captured response and error pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      timer_q <= timer_d;
    end
  end

  assign bus.mem_valid = valid_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = wstrb_q;

  // The instruction retires in DONE, so that is the only cycle a pending access does not stall.
  assign core_stall = core_req & (state_q != DONE);
  assign core_rdata = rdata_q;
  assign core_err   = err_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Directed bench for dmem_bus_bridge: expected transfer results are queued at issue
// and compared when the bridge reaches its completion cycle.
module tb_dmem_bus_bridge;

  localparam int          TO  = 8;
  localparam logic [31:0] ERR = 32'hFFFF_FFFF;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
    logic        err;
    int          vcycles;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        core_req;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [3:0]  core_wmask;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        core_err;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rdata;
  exp_t        sb[$];

  dmem_bus_if bus();

  dmem_bus_bridge #(
    .TIMEOUT_CYCLES(TO),
    .ERR_RDATA     (ERR)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .core_req  (core_req),
    .core_addr (core_addr),
    .core_wdata(core_wdata),
    .core_wmask(core_wmask),
    .core_rdata(core_rdata),
    .core_stall(core_stall),
    .core_err  (core_err),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one access; ready_at is the BUSY cycle index (0 = first) that sees mem_ready, -1 = never.
  task automatic access(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wmask, input int ready_at,
                        input logic [31:0] rresp);
    exp_t e;
    exp_t got;
    int   n;
    e.addr  = {addr[31:2], 2'b00};
    e.wdata = wdata;
    e.strb  = wmask;
    if (ready_at >= 0 && ready_at < TO) begin
      e.rdata   = rresp;
      e.err     = 1'b0;
      e.vcycles = ready_at + 1;
    end else begin
      e.rdata   = ERR;
      e.err     = 1'b1;
      e.vcycles = TO;
    end
    sb.push_back(e);

    core_req      = 1'b1;
    core_addr     = addr;
    core_wdata    = wdata;
    core_wmask    = wmask;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("req_stall", 32'(core_stall), 32'd1);
    chk("req_valid", 32'(bus.mem_valid), 32'd0);

    n = 0;
    forever begin
      @(posedge clk); #1;
      core_addr     = ~addr;
      core_wdata    = ~wdata;
      core_wmask    = ~wmask;
      bus.mem_ready = (n == ready_at);
      bus.mem_rdata = (n == ready_at) ? rresp : $urandom;
      @(negedge clk);
      if (!bus.mem_valid || n > TO + 2) break;
      chk("busy_addr", bus.mem_addr, e.addr);
      chk("busy_wdata", bus.mem_wdata, e.wdata);
      chk("busy_wstrb", 32'(bus.mem_wstrb), 32'(e.strb));
      chk("busy_stall", 32'(core_stall), 32'd1);
      chk("busy_err", 32'(core_err), 32'd0);
      chk("busy_rdata_hold", core_rdata, last_rdata);
      n++;
    end

    got = sb.pop_front();
    chk("valid_cycles", 32'(n), 32'(got.vcycles));
    chk("done_valid", 32'(bus.mem_valid), 32'd0);
    chk("done_stall", 32'(core_stall), 32'd0);
    chk("done_rdata", core_rdata, got.rdata);
    chk("done_err", 32'(core_err), 32'(got.err));
    last_rdata = got.rdata;

    @(posedge clk); #1;
    core_req      = 1'b0;
    core_addr     = '0;
    core_wdata    = '0;
    core_wmask    = '0;
    bus.mem_ready = 1'b0;
  endtask

  initial begin
    resetn        = 1'b0;
    core_req      = 1'b0;
    core_addr     = '0;
    core_wdata    = '0;
    core_wmask    = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    last_rdata    = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(bus.mem_valid), 32'd0);
    chk("rst_stall", 32'(core_stall), 32'd0);
    chk("rst_rdata", core_rdata, 32'd0);
    chk("rst_err", 32'(core_err), 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // Zero-wait load, unaligned byte address
    access(32'h0000_1006, 32'h0, 4'b0000, 0, 32'hDEAD_BEEF);

    // Store with three wait states; response data is still captured
    access(32'h0000_2000, 32'hABCD_0000, 4'b1100, 3, 32'h1234_5678);

    // Timeout, then confirm the error is a single-cycle pulse and the error data holds
    access(32'h0000_3008, 32'h0, 4'b0000, -1, 32'h0);
    @(negedge clk);
    chk("post_to_err", 32'(core_err), 32'd0);
    chk("post_to_rdata", core_rdata, ERR);
    chk("post_to_valid", 32'(bus.mem_valid), 32'd0);
    @(posedge clk); #1;

    // Ready on the final timeout cycle completes normally
    access(32'h0000_400C, 32'h0, 4'b0000, TO - 1, 32'h0BAD_F00D);

    // Asynchronous reset in the middle of a transfer
    core_req   = 1'b1;
    core_addr  = 32'h0000_5000;
    core_wmask = 4'b0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_valid_before", 32'(bus.mem_valid), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_valid_async", 32'(bus.mem_valid), 32'd0);
    chk("mid_rdata_async", core_rdata, 32'd0);
    chk("mid_addr_async", bus.mem_addr, 32'd0);
    chk("mid_err_async", 32'(core_err), 32'd0);
    core_req = 1'b0;
    @(posedge clk); #1;
    resetn     = 1'b1;
    last_rdata = '0;
    @(posedge clk); #1;

    // Back-to-back loads after reset release
    access(32'h0000_6004, 32'h0, 4'b0000, 0, 32'hCAFE_0001);
    access(32'h0000_6008, 32'h0, 4'b0000, 2, 32'hCAFE_0002);
    @(negedge clk);
    chk("final_err", 32'(core_err), 32'd0);
    chk("final_rdata", core_rdata, 32'hCAFE_0002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
